// File: rtl/sdram_burst_reader.sv
// rtl/sdram_burst_reader.sv - Avalon-MM burst reader feeding a FWFT stream FIFO
// Optional repeat-pass mode enabled by defining SDRAM_BURST_READER_LOOP_EN.
module sdram_burst_reader #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 64,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
`ifdef SDRAM_BURST_READER_LOOP_EN
  input  logic              cmd_loop,
`endif
  input  logic              abort,
  output logic [ADDR_W-1:0] avm_address,
  output logic [7:0]        avm_burstcount,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ABORT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
  logic [LEN_W-1:0]  rem_q, rem_d, len_q, len_d, popped_q, popped_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d, count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              rd_q, rd_d, loop_q, loop_d, cmd_loop_w;
  logic [7:0]        bc_q, bc_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic [8:0] room;
  logic [7:0] size;
  logic       space_ok, accept, beat, wr_en, pop;

`ifdef SDRAM_BURST_READER_LOOP_EN
  assign cmd_loop_w = cmd_loop;
`else
  assign cmd_loop_w = 1'b0;
`endif

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign avm_read       = rd_q;
  assign avm_address    = addr_q;
  assign avm_burstcount = bc_q;
  assign out_valid      = (count_q != '0) && (state_q != ABORT);
  assign out_data       = mem_q[rd_ptr_q];
  assign out_last       = out_valid && (popped_q == len_q - 1'b1);

  // Burst is clipped at the next BURST_LEN-aligned boundary.
  always_comb begin
    room     = 9'(BURST_LEN) - 9'(addr_q & ADDR_W'(BURST_LEN - 1));
    size     = (rem_q < LEN_W'(room)) ? 8'(rem_q) : 8'(room);
    space_ok = (SUM_W'(count_q) + SUM_W'(inflight_q) + SUM_W'(size)) <= SUM_W'(FIFO_DEPTH);
    accept   = rd_q && !avm_waitrequest;
    // Beats with nothing outstanding belong to a transfer cut off by reset.
    beat     = avm_readdatavalid && (state_q != IDLE) && (inflight_q != '0);
    wr_en    = beat && (state_q == ISSUE || state_q == DRAIN);
    pop      = out_valid && out_ready;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    base_d     = base_q;
    rem_d      = rem_q;
    len_d      = len_q;
    loop_d     = loop_q;
    rd_d       = rd_q;
    bc_d       = bc_q;
    popped_d   = popped_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + (wr_en ? CNT_W'(1) : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
    inflight_d = inflight_q + (accept ? CNT_W'(bc_q) : CNT_W'(0)) - (beat ? CNT_W'(1) : CNT_W'(0));

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      popped_d = out_last ? '0 : popped_q + 1'b1;
    end

    if (accept) begin
      rd_d   = 1'b0;
      addr_d = addr_q + ADDR_W'(bc_q);
      rem_d  = rem_q - LEN_W'(bc_q);
      if (loop_q && rem_d == '0) begin
        addr_d = base_q;
        rem_d  = len_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_len != '0) begin
          state_d  = ISSUE;
          addr_d   = cmd_addr;
          base_d   = cmd_addr;
          rem_d    = cmd_len;
          len_d    = cmd_len;
          loop_d   = cmd_loop_w;
          popped_d = '0;
        end
      end
      ISSUE: begin
        if (abort) state_d = ABORT;
        else if (rem_q == '0 && !rd_q) state_d = DRAIN;
        else if (!rd_q && space_ok) begin
          rd_d = 1'b1;
          bc_d = size;
        end
      end
      DRAIN: begin
        if (abort) state_d = ABORT;
        else if (pop && out_last) state_d = IDLE;
      end
      ABORT: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        if (inflight_q == '0 && !rd_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      base_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      rd_q       <= 1'b0;
      bc_q       <= '0;
      popped_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      rd_q       <= rd_d;
      bc_q       <= bc_d;
      popped_q   <= popped_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= avm_readdata;
  end
endmodule
